// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/load-store memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_e;

  // Wide enough for any supported data width; users slice the low DATA_W/8 bits.
  localparam int MAX_BE_W = 64;
  localparam logic [MAX_BE_W-1:0] FETCH_BE_ALL = '1;

  // Width of a counter that must hold values 0..limit.
  function automatic int starve_cnt_w(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side handshakes around mem_arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_W-1:0]     if_rdata;

  logic                  dm_req;
  logic                  dm_we;
  logic [DATA_W/8-1:0]   dm_be;
  logic [ADDR_W-1:0]     dm_addr;
  logic [DATA_W-1:0]     dm_wdata;
  logic                  dm_gnt;
  logic                  dm_rvalid;
  logic [DATA_W-1:0]     dm_rdata;

  logic                  mem_req;
  logic                  mem_we;
  logic [DATA_W/8-1:0]   mem_be;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [DATA_W-1:0]     mem_rdata;

  // Arbiter view: requester inputs and memory responses in, grants and memory request out.
  modport slave (
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output dm_gnt, dm_rvalid, dm_rdata,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );

  // Environment view: requesters and memory model.
  modport master (
    output if_req, if_addr,
    output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arb_prio.sv
// Winner selection between fetch and load/store, data first.
// MEM_ARB_STARVE_GUARD_EN adds a starvation counter that forces a fetch win.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       if_req,
  input  logic       dm_req,
  input  logic       arb_en,
  output logic       any_req,
  output arb_owner_e winner
);

  assign any_req = if_req | dm_req;

`ifdef MEM_ARB_STARVE_GUARD_EN

  localparam int CNT_W = starve_cnt_w(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt_reg;
  logic             force_if;

  assign force_if = if_req && (cnt_reg >= CNT_MAX);
  assign winner   = (dm_req && !force_if) ? OWN_DM : OWN_IF;

  // Counts data wins that left a fetch waiting; any fetch win or idle fetch side restarts it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (arb_en) begin
      if ((winner == OWN_IF) || !if_req) begin
        cnt_reg <= '0;
      end else if (cnt_reg < CNT_MAX) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

`else

  assign winner = dm_req ? OWN_DM : OWN_IF;

  logic unused_guard;
  assign unused_guard = ^{clk, reset, arb_en, starve_cnt_w(STARVE_LIMIT)};

`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store, one
// transaction in flight. MEM_ARB_STARVE_GUARD_EN enables the fetch starvation guard.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  localparam int BE_W = DATA_W / 8;

  arb_state_e state_reg;
  arb_owner_e owner_reg;

  logic       any_req;
  logic       arb_en;
  arb_owner_e winner;
  logic       issuing;
  logic       waiting;
  logic       own_if;
  logic       own_dm;

  assign issuing = (state_reg == ISSUE);
  assign waiting = (state_reg == WAIT);
  assign own_if  = (owner_reg == OWN_IF);
  assign own_dm  = (owner_reg == OWN_DM);

  // Arbitration happens leaving IDLE or chaining straight out of a completed WAIT.
  assign arb_en = any_req && ((state_reg == IDLE) || (waiting && bus.mem_rvalid));

  mem_arb_prio #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_prio (
    .clk     (clk),
    .reset   (reset),
    .if_req  (bus.if_req),
    .dm_req  (bus.dm_req),
    .arb_en  (arb_en),
    .any_req (any_req),
    .winner  (winner)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      owner_reg <= OWN_DM;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            owner_reg <= winner;
            state_reg <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.mem_gnt) begin
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          if (bus.mem_rvalid) begin
            if (any_req) begin
              owner_reg <= winner;
              state_reg <= ISSUE;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Byte-lane attribute mux: fetches enable every lane and carry no write data.
  logic [BE_W-1:0]   be_mux;
  logic [DATA_W-1:0] wdata_mux;

  for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
    assign be_mux[gi]             = issuing & (own_if ? FETCH_BE_ALL[gi] : bus.dm_be[gi]);
    assign wdata_mux[gi*8 +: 8]   = (issuing && own_dm) ? bus.dm_wdata[gi*8 +: 8] : 8'h00;
  end

  assign bus.mem_req   = issuing;
  assign bus.mem_we    = issuing && own_dm && bus.dm_we;
  assign bus.mem_be    = be_mux;
  assign bus.mem_wdata = wdata_mux;
  assign bus.mem_addr  = issuing ? (own_if ? bus.if_addr : bus.dm_addr) : '0;

  // Grants and responses reach only the current owner; stray responses are dropped.
  assign bus.if_gnt    = issuing && own_if && bus.mem_gnt;
  assign bus.dm_gnt    = issuing && own_dm && bus.mem_gnt;
  assign bus.if_rvalid = waiting && own_if && bus.mem_rvalid;
  assign bus.dm_rvalid = waiting && own_dm && bus.mem_rvalid;
  assign bus.if_rdata  = (waiting && own_if) ? bus.mem_rdata : '0;
  assign bus.dm_rdata  = (waiting && own_dm) ? bus.mem_rdata : '0;

endmodule
